// File: rtl/bus_responder_if.sv
// ============================================================================
//  bus_responder_if : CPU / external bus / OAM / interrupt signal bundle
//  Rev 1.0
// ============================================================================
`default_nettype none

interface bus_responder_if;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] ext_addr;
    logic        ext_enable;
    logic        ext_write;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic [4:0]  irq_req;
    logic [4:0]  irq_pending;
    logic        dma_active;

    modport slave (
        input  cpu_addr, cpu_enable, cpu_write, cpu_wdata, ext_rdata, irq_req,
        output cpu_rdata, ext_addr, ext_enable, ext_write, ext_wdata,
               oam_we, oam_addr, oam_wdata, irq_pending, dma_active
    );

    modport master (
        output cpu_addr, cpu_enable, cpu_write, cpu_wdata, ext_rdata, irq_req,
        input  cpu_rdata, ext_addr, ext_enable, ext_write, ext_wdata,
               oam_we, oam_addr, oam_wdata, irq_pending, dma_active
    );
endinterface

`default_nettype wire

// File: rtl/bus_responder.sv
// ============================================================================
//  bus_responder : SM83 system-bus responder (WRAM, HRAM, IF/IE, OAM DMA)
//  Rev 1.0
// ============================================================================
`default_nettype none

module bus_responder #(
    parameter int DMA_LEN     = 160,
    parameter int DMA_STARTUP = 1
) (
    input  logic           clk,
    input  logic           reset,
    bus_responder_if.slave bus
);

    localparam int SCW = (DMA_STARTUP > 1) ? $clog2(DMA_STARTUP) : 1;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_START = 2'd1,
        DMA_XFER  = 2'd2
    } dma_state_t;

    typedef enum logic [2:0] {
        R_WRAM = 3'd0,
        R_HRAM = 3'd1,
        R_IF   = 3'd2,
        R_IE   = 3'd3,
        R_DMA  = 3'd4,
        R_EXT  = 3'd5
    } region_t;

    function automatic region_t decode(input logic [15:0] a);
        if (a >= 16'hC000 && a <= 16'hFDFF) return R_WRAM;
        if (a >= 16'hFF80 && a <= 16'hFFFE) return R_HRAM;
        if (a == 16'hFF0F)                  return R_IF;
        if (a == 16'hFFFF)                  return R_IE;
        if (a == 16'hFF46)                  return R_DMA;
        return R_EXT;
    endfunction

    logic [1:0]     phase_q;
    logic [7:0]     wram_q [8192];
    logic [7:0]     hram_q [127];
    logic [4:0]     if_q, if_d;
    logic [7:0]     ie_q, dma_reg_q;
    logic [7:0]     rdata_q, dma_data_q, rd_val;
    dma_state_t     state_q, state_d;
    logic [7:0]     index_q, index_d, src_hi_q, src_hi_d;
    logic [SCW-1:0] start_cnt_q, start_cnt_d;

    logic           xfer, wr_commit, cpu_wr_ok, ff46_wr;
    region_t        cpu_region, dma_region;
    logic [15:0]    dma_addr;

    assign xfer       = (state_q == DMA_XFER);
    assign cpu_region = decode(bus.cpu_addr);
    assign dma_addr   = {src_hi_q, index_q};
    assign dma_region = decode(dma_addr);
    assign wr_commit  = bus.cpu_enable && bus.cpu_write && (phase_q == 2'd3);
    // While the DMA owns the bus, only HRAM and the DMA register stay writable.
    assign cpu_wr_ok  = wr_commit && (!xfer || cpu_region == R_HRAM || cpu_region == R_DMA);
    assign ff46_wr    = cpu_wr_ok && (cpu_region == R_DMA);

    always_comb begin
        rd_val = 8'hFF;
        case (cpu_region)
            R_WRAM:  rd_val = wram_q[bus.cpu_addr[12:0]];
            R_HRAM:  rd_val = hram_q[bus.cpu_addr[6:0]];
            R_IF:    rd_val = {3'b111, if_q};
            R_IE:    rd_val = ie_q;
            R_DMA:   rd_val = dma_reg_q;
            default: rd_val = bus.ext_rdata;
        endcase
        if (xfer && cpu_region != R_HRAM) rd_val = 8'hFF;
    end

    always_comb begin
        if_d = if_q;
        if (cpu_wr_ok && cpu_region == R_IF) if_d = bus.cpu_wdata[4:0];
        if_d = if_d | bus.irq_req;
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        src_hi_d    = src_hi_q;
        start_cnt_d = start_cnt_q;
        case (state_q)
            DMA_START: if (phase_q == 2'd3) begin
                if (start_cnt_q == SCW'(DMA_STARTUP - 1)) state_d = DMA_XFER;
                else start_cnt_d = start_cnt_q + SCW'(1);
            end
            DMA_XFER: if (phase_q == 2'd3) begin
                if (index_q == 8'(DMA_LEN - 1)) state_d = DMA_IDLE;
                else index_d = index_q + 8'd1;
            end
            default: ;
        endcase
        // A new FF46 write always (re)starts the engine, even mid-transfer.
        if (ff46_wr) begin
            state_d     = DMA_START;
            index_d     = 8'd0;
            start_cnt_d = '0;
            src_hi_d    = (bus.cpu_wdata >= 8'hE0) ? bus.cpu_wdata - 8'h20 : bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= 2'd0;
            rdata_q     <= 8'hFF;
            if_q        <= 5'd0;
            ie_q        <= 8'd0;
            dma_reg_q   <= 8'd0;
            dma_data_q  <= 8'd0;
            state_q     <= DMA_IDLE;
            index_q     <= 8'd0;
            src_hi_q    <= 8'd0;
            start_cnt_q <= '0;
        end else begin
            phase_q     <= phase_q + 2'd1;
            if_q        <= if_d;
            state_q     <= state_d;
            index_q     <= index_d;
            src_hi_q    <= src_hi_d;
            start_cnt_q <= start_cnt_d;
            if (phase_q == 2'd2 && bus.cpu_enable && !bus.cpu_write) rdata_q <= rd_val;
            if (cpu_wr_ok && cpu_region == R_IE) ie_q <= bus.cpu_wdata;
            if (ff46_wr) dma_reg_q <= bus.cpu_wdata;
            if (xfer && phase_q == 2'd2)
                dma_data_q <= (dma_region == R_WRAM) ? wram_q[dma_addr[12:0]] : bus.ext_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_wr_ok && cpu_region == R_WRAM) wram_q[bus.cpu_addr[12:0]] <= bus.cpu_wdata;
        if (cpu_wr_ok && cpu_region == R_HRAM) hram_q[bus.cpu_addr[6:0]] <= bus.cpu_wdata;
    end

    always_comb begin
        bus.ext_enable = 1'b0;
        bus.ext_write  = 1'b0;
        bus.ext_addr   = 16'd0;
        bus.ext_wdata  = 8'd0;
        if (xfer) begin
            if (dma_region == R_EXT) begin
                bus.ext_enable = 1'b1;
                bus.ext_addr   = dma_addr;
            end
        end else if (bus.cpu_enable && cpu_region == R_EXT) begin
            bus.ext_enable = 1'b1;
            bus.ext_addr   = bus.cpu_addr;
            bus.ext_wdata  = bus.cpu_write ? bus.cpu_wdata : 8'd0;
            bus.ext_write  = bus.cpu_write && (phase_q == 2'd3);
        end
    end

    assign bus.cpu_rdata   = rdata_q;
    assign bus.oam_we      = xfer && (phase_q == 2'd3);
    assign bus.oam_addr    = index_q;
    assign bus.oam_wdata   = dma_data_q;
    assign bus.irq_pending = ie_q[4:0] & if_q;
    assign bus.dma_active  = xfer;

endmodule

`default_nettype wire

// File: tb/tb_bus_responder.sv
// ============================================================================
//  tb_bus_responder : directed table-driven bench for bus_responder
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_responder;

    logic clk = 1'b0;
    logic reset;
    bus_responder_if bus();

    bus_responder #(.DMA_LEN(160), .DMA_STARTUP(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic        wr;
        logic [7:0]  wd;
        logic [7:0]  erd;
        logic [7:0]  exp_rd;
        logic        exp_ext;
        string       nm;
    } vec_t;

    vec_t vt [14];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  s_rdata, s_ext_wdata, s_oam_addr, s_oam_wdata;
    logic [15:0] s_ext_addr;
    logic        s_ext_en, s_ext_wr3, s_ext_wr_bad, s_oam_bad;
    int          s_oam_cnt, s_act_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One CPU M-cycle, entered and left just after the edge that starts phase 0.
    task automatic mcyc(input logic [15:0] a, input logic en, input logic wr,
                        input logic [7:0] wd, input logic [7:0] erd);
        bus.cpu_addr   = a;
        bus.cpu_enable = en;
        bus.cpu_write  = wr;
        bus.cpu_wdata  = wd;
        bus.ext_rdata  = erd;
        s_ext_en = 1'b0; s_ext_wr3 = 1'b0; s_ext_wr_bad = 1'b0; s_oam_bad = 1'b0;
        s_oam_cnt = 0; s_act_cnt = 0; s_ext_addr = 16'd0; s_ext_wdata = 8'd0;
        s_oam_addr = 8'd0; s_oam_wdata = 8'd0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            if (bus.ext_enable) begin
                if (!s_ext_en) s_ext_addr = bus.ext_addr;
                s_ext_en = 1'b1;
            end
            if (bus.ext_write) begin
                if (p == 3) begin s_ext_wr3 = 1'b1; s_ext_wdata = bus.ext_wdata; end
                else s_ext_wr_bad = 1'b1;
            end
            if (bus.oam_we) begin
                s_oam_cnt++;
                s_oam_addr  = bus.oam_addr;
                s_oam_wdata = bus.oam_wdata;
                if (p != 3) s_oam_bad = 1'b1;
            end
            if (bus.dma_active) s_act_cnt++;
            if (p == 3) s_rdata = bus.cpu_rdata;
            @(posedge clk);
        end
        #1;
        bus.cpu_enable = 1'b0;
        bus.cpu_write  = 1'b0;
    endtask

    task automatic idle();
        mcyc(16'h0000, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        int errs, tot_act;
        bit done;

        vt[0]  = '{16'hC123, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, "wr_c123"};
        vt[1]  = '{16'hC123, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, "rd_c123"};
        vt[2]  = '{16'hE123, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, "rd_e123_echo"};
        vt[3]  = '{16'hFF85, 1'b1, 8'h33, 8'h00, 8'h00, 1'b0, "wr_ff85"};
        vt[4]  = '{16'hFF85, 1'b0, 8'h00, 8'h00, 8'h33, 1'b0, "rd_ff85"};
        vt[5]  = '{16'h1234, 1'b0, 8'h00, 8'hA7, 8'hA7, 1'b1, "rd_ext_1234"};
        vt[6]  = '{16'h2000, 1'b1, 8'h99, 8'h00, 8'h00, 1'b1, "wr_ext_2000"};
        vt[7]  = '{16'hFF0F, 1'b0, 8'h00, 8'h00, 8'hE0, 1'b0, "rd_if_reset"};
        vt[8]  = '{16'hFFFF, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0, "wr_ie"};
        vt[9]  = '{16'hFFFF, 1'b0, 8'h00, 8'h00, 8'h05, 1'b0, "rd_ie"};
        vt[10] = '{16'hFE00, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b1, "rd_ext_fe00"};
        vt[11] = '{16'hD000, 1'b1, 8'hAB, 8'h00, 8'h00, 1'b0, "wr_d000"};
        vt[12] = '{16'hD001, 1'b1, 8'hCD, 8'h00, 8'h00, 1'b0, "wr_d001"};
        vt[13] = '{16'hFF80, 1'b1, 8'h77, 8'h00, 8'h00, 1'b0, "wr_ff80"};

        reset = 1'b1;
        bus.cpu_addr = 16'd0; bus.cpu_enable = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_wdata = 8'd0; bus.ext_rdata = 8'd0; bus.irq_req = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", 32'(bus.cpu_rdata), 32'hFF);
        chk("reset_ext_en", 32'(bus.ext_enable), 32'h0);
        chk("reset_oam_we", 32'(bus.oam_we), 32'h0);
        chk("reset_dma_active", 32'(bus.dma_active), 32'h0);
        chk("reset_irq_pending", 32'(bus.irq_pending), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic accesses from the vector table.
        for (int i = 0; i < 14; i++) begin
            mcyc(vt[i].a, 1'b1, vt[i].wr, vt[i].wd, vt[i].erd);
            if (!vt[i].wr) chk({vt[i].nm, "_rdata"}, 32'(s_rdata), 32'(vt[i].exp_rd));
            chk({vt[i].nm, "_ext_en"}, 32'(s_ext_en), 32'(vt[i].exp_ext));
            chk({vt[i].nm, "_ext_wr_early"}, 32'(s_ext_wr_bad), 32'h0);
            if (vt[i].exp_ext) chk({vt[i].nm, "_ext_addr"}, 32'(s_ext_addr), 32'(vt[i].a));
            if (vt[i].wr && vt[i].exp_ext) begin
                chk({vt[i].nm, "_ext_wr3"}, 32'(s_ext_wr3), 32'h1);
                chk({vt[i].nm, "_ext_wdata"}, 32'(s_ext_wdata), 32'(vt[i].wd));
            end
        end

        // Interrupt request pulse, then IF write racing a request on the same edge.
        bus.irq_req = 5'b00001;
        @(posedge clk); #1;
        bus.irq_req = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_pending_vblank", 32'(bus.irq_pending), 32'h01);
        mcyc(16'hFF0F, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("rd_if_e1", 32'(s_rdata), 32'hE1);
        bus.cpu_addr = 16'hFF0F; bus.cpu_enable = 1'b1; bus.cpu_write = 1'b1; bus.cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 bus.irq_req = 5'b00100;
        @(posedge clk);
        #1 bus.irq_req = 5'b00000;
        bus.cpu_enable = 1'b0; bus.cpu_write = 1'b0;
        mcyc(16'hFF0F, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("rd_if_req_wins", 32'(s_rdata), 32'hE4);
        chk("irq_pending_timer", 32'(bus.irq_pending), 32'h04);

        // Full OAM DMA from C000.
        for (int i = 0; i < 160; i++) mcyc(16'hC000 + 16'(i), 1'b1, 1'b1, 8'(i), 8'h00);
        mcyc(16'hFF46, 1'b1, 1'b1, 8'hC0, 8'h00);
        idle();
        chk("dma_startup_active", 32'(s_act_cnt), 32'h0);
        chk("dma_startup_oam", 32'(s_oam_cnt), 32'h0);
        errs = 0; tot_act = 0;
        for (int i = 0; i < 160; i++) begin
            idle();
            tot_act += s_act_cnt;
            if (s_oam_cnt != 1 || s_oam_bad || s_oam_addr != 8'(i) || s_oam_wdata != 8'(i) || s_ext_en)
                errs++;
        end
        chk("dma_pulse_errors", 32'(errs), 32'h0);
        chk("dma_active_clks", 32'(tot_act), 32'd640);
        idle();
        chk("dma_done_active", 32'(s_act_cnt), 32'h0);
        chk("dma_done_oam", 32'(s_oam_cnt), 32'h0);

        // CPU accesses while the DMA owns the bus.
        mcyc(16'hFF46, 1'b1, 1'b1, 8'hC0, 8'h00);
        idle();
        mcyc(16'hC000, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("dma_rd_c000", 32'(s_rdata), 32'hFF);
        mcyc(16'hFF80, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("dma_rd_ff80", 32'(s_rdata), 32'h77);
        mcyc(16'hD000, 1'b1, 1'b1, 8'h11, 8'h00);
        mcyc(16'hFF81, 1'b1, 1'b1, 8'h22, 8'h00);
        mcyc(16'h1234, 1'b1, 1'b0, 8'h00, 8'h55);
        chk("dma_rd_ext_blocked", 32'(s_rdata), 32'hFF);
        chk("dma_rd_ext_no_en", 32'(s_ext_en), 32'h0);
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            idle();
            if (!bus.dma_active) done = 1'b1;
        end
        chk("dma_end_timeout", 32'(done), 32'h1);
        mcyc(16'hD000, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("dropped_wr_d000", 32'(s_rdata), 32'hAB);
        mcyc(16'hFF81, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("hram_wr_during_dma", 32'(s_rdata), 32'h22);
        mcyc(16'hFF46, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("rd_ff46", 32'(s_rdata), 32'hC0);

        // Restart at transfer 50, then reset at transfer 10.
        mcyc(16'hFF46, 1'b1, 1'b1, 8'hC0, 8'h00);
        idle();
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            idle();
            errs += s_oam_cnt;
        end
        chk("restart_pre_pulses", 32'(errs), 32'd50);
        mcyc(16'hFF46, 1'b1, 1'b1, 8'hD0, 8'h00);
        chk("restart_xfer50_addr", 32'(s_oam_addr), 32'd50);
        idle();
        chk("restart_startup_oam", 32'(s_oam_cnt), 32'h0);
        chk("restart_startup_active", 32'(s_act_cnt), 32'h0);
        idle();
        chk("restart_t0_addr", 32'(s_oam_addr), 32'h00);
        chk("restart_t0_data", 32'(s_oam_wdata), 32'hAB);
        idle();
        chk("restart_t1_addr", 32'(s_oam_addr), 32'h01);
        chk("restart_t1_data", 32'(s_oam_wdata), 32'hCD);
        for (int i = 2; i < 10; i++) idle();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_dma_active", 32'(bus.dma_active), 32'h0);
        chk("abort_oam_we", 32'(bus.oam_we), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            idle();
            errs += s_oam_cnt + s_act_cnt;
        end
        chk("abort_quiet", 32'(errs), 32'h0);

        // External-source DMA, then echo-source restart.
        mcyc(16'hFF46, 1'b1, 1'b1, 8'h40, 8'h00);
        idle();
        mcyc(16'h0000, 1'b0, 1'b0, 8'h00, 8'h5C);
        chk("ext_dma_en", 32'(s_ext_en), 32'h1);
        chk("ext_dma_addr0", 32'(s_ext_addr), 32'h4000);
        chk("ext_dma_data0", 32'(s_oam_wdata), 32'h5C);
        mcyc(16'h0000, 1'b0, 1'b0, 8'h00, 8'h5C);
        chk("ext_dma_addr1", 32'(s_ext_addr), 32'h4001);
        mcyc(16'hFF46, 1'b1, 1'b1, 8'hE0, 8'h00);
        idle();
        idle();
        chk("echo_dma_no_ext", 32'(s_ext_en), 32'h0);
        idle();
        chk("echo_dma_t1_addr", 32'(s_oam_addr), 32'h01);
        chk("echo_dma_t1_data", 32'(s_oam_wdata), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
